// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD fill scheduler.
//   LCD_CASET/RASET/RAMWR : ST7789 window/memory-write command bytes
//   rect_t                : packed fill request {x0, x1, y0, y1, color}
//   fsm_e                 : scheduler state encoding
//   window_word()         : builds one word of a CASET/RASET group
package lcd_pkg;

  localparam logic [7:0] LCD_CASET = 8'h2A;
  localparam logic [7:0] LCD_RASET = 8'h2B;
  localparam logic [7:0] LCD_RAMWR = 8'h2C;

  typedef struct packed {
    logic [8:0]  x0;
    logic [8:0]  x1;
    logic [8:0]  y0;
    logic [8:0]  y1;
    logic [15:0] color;
  } rect_t;

  typedef enum logic [2:0] {
    StIdle,
    StCaset,
    StRaset,
    StRamwr,
    StPixel,
    StDone
  } fsm_e;

  // Word idx of a 5-word address group: command, then start hi/lo, end hi/lo.
  function automatic logic [8:0] window_word(input logic [7:0]  cmd,
                                             input logic [15:0] first,
                                             input logic [15:0] last,
                                             input logic [2:0]  idx);
    logic [8:0] w;
    case (idx)
      3'd0:    w = {1'b0, cmd};
      3'd1:    w = {1'b1, first[15:8]};
      3'd2:    w = {1'b1, first[7:0]};
      3'd3:    w = {1'b1, last[15:8]};
      default: w = {1'b1, last[7:0]};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector, one bit per requester
//   ptr     : index to start scanning from (wraps around)
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : index of the granted requester
//   any     : at least one request pending
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IdxW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IdxW-1:0]  gnt_idx,
  output logic             any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (!any && req[(int'(ptr) + k) % int'(N_REQ)]) begin
        any                                  = 1'b1;
        gnt[(int'(ptr) + k) % int'(N_REQ)]   = 1'b1;
        gnt_idx                              = IdxW'((int'(ptr) + k) % int'(N_REQ));
      end
    end
  end

endmodule

// File: rtl/lcd_fill_scheduler.sv
// Arbitrates rectangle-fill requests and streams the ST7789 command/data
// words for each accepted request to the SPI byte transmitter.
//   clk, resetn          : clock, async active-low reset
//   init_done            : panel init finished; gates new grants only
//   req_valid/req_rect   : per-requester request and rectangle (52 bits each)
//   req_ready/req_err    : one-cycle accept pulse / reject pulse
//   out_valid/out_ready  : word stream handshake, out_word = {rs, byte}
//   busy, done, grant_id : streaming status, end-of-fill pulse, granted index
module lcd_fill_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned COL_OFS = 40,
  parameter int unsigned ROW_OFS = 53,
  parameter int unsigned MAX_W   = 240,
  parameter int unsigned MAX_H   = 135
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       init_done,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*52-1:0]        req_rect,
  output logic [N_REQ-1:0]           req_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8:0]                 out_word,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  fsm_e            state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [2:0]      idx_q, idx_d;
  logic [16:0]     cnt_q, cnt_d;
  rect_t           rect_q, rect_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IdxW-1:0]  arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IdxW  (IdxW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  rect_t       cand;
  logic        cand_bad;
  logic [16:0] cand_w, cand_h, cand_npix;
  logic        grant_fire;

  assign cand = req_rect[52*arb_idx +: 52];

  assign cand_bad = (cand.x0 > cand.x1) || (cand.y0 > cand.y1) ||
                    ({23'd0, cand.x1} >= MAX_W) || ({23'd0, cand.y1} >= MAX_H);

  assign cand_w    = {8'd0, cand.x1} - {8'd0, cand.x0} + 17'd1;
  assign cand_h    = {8'd0, cand.y1} - {8'd0, cand.y0} + 17'd1;
  assign cand_npix = cand_w * cand_h;

  // resetn in the gate keeps req_ready low while reset is held.
  assign grant_fire = (state_q == StIdle) && init_done && arb_any && resetn;

  logic [15:0] xs0, xs1, ys0, ys1;
  assign xs0 = {7'd0, rect_q.x0} + 16'(COL_OFS);
  assign xs1 = {7'd0, rect_q.x1} + 16'(COL_OFS);
  assign ys0 = {7'd0, rect_q.y0} + 16'(ROW_OFS);
  assign ys1 = {7'd0, rect_q.y1} + 16'(ROW_OFS);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rect_d    = rect_q;
    req_ready = '0;
    req_err   = '0;
    out_valid = 1'b0;
    out_word  = '0;

    unique case (state_q)
      StIdle: begin
        if (grant_fire) begin
          req_ready = arb_gnt;
          grant_d   = arb_idx;
          ptr_d     = (arb_idx == IdxW'(N_REQ - 1)) ? '0 : arb_idx + IdxW'(1);
          if (cand_bad) begin
            req_err = arb_gnt;
          end else begin
            rect_d  = cand;
            cnt_d   = cand_npix;
            idx_d   = '0;
            state_d = StCaset;
          end
        end
      end
      StCaset: begin
        out_valid = 1'b1;
        out_word  = window_word(LCD_CASET, xs0, xs1, idx_q);
        if (out_ready) begin
          if (idx_q == 3'd4) begin
            idx_d   = '0;
            state_d = StRaset;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StRaset: begin
        out_valid = 1'b1;
        out_word  = window_word(LCD_RASET, ys0, ys1, idx_q);
        if (out_ready) begin
          if (idx_q == 3'd4) begin
            idx_d   = '0;
            state_d = StRamwr;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StRamwr: begin
        out_valid = 1'b1;
        out_word  = {1'b0, LCD_RAMWR};
        if (out_ready) begin
          idx_d   = '0;
          state_d = StPixel;
        end
      end
      StPixel: begin
        // idx_q[0] selects high (0) or low (1) color byte of the current pixel.
        out_valid = 1'b1;
        out_word  = idx_q[0] ? {1'b1, rect_q.color[7:0]} : {1'b1, rect_q.color[15:8]};
        if (out_ready) begin
          if (idx_q[0]) begin
            idx_d = '0;
            cnt_d = cnt_q - 17'd1;
            if (cnt_q == 17'd1) state_d = StDone;
          end else begin
            idx_d = 3'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy     = (state_q == StCaset) || (state_q == StRaset) ||
                    (state_q == StRamwr) || (state_q == StPixel);
  assign done     = (state_q == StDone);
  assign grant_id = grant_fire ? arb_idx : grant_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rect_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rect_q  <= rect_d;
    end
  end

endmodule

// File: tb/tb_lcd_fill_scheduler.sv
// Scoreboard bench for lcd_fill_scheduler: stimulus pushes expected words,
// a negedge monitor pops and compares every transferred word and checks
// that stalled words stay put.
module tb_lcd_fill_scheduler;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         init_done = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [103:0] req_rect = '0;
  logic [1:0]   req_ready, req_err;
  logic         out_valid, busy, done;
  logic [8:0]   out_word;
  logic [0:0]   grant_id;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_fill_scheduler #(
    .N_REQ   (2),
    .COL_OFS (40),
    .ROW_OFS (53),
    .MAX_W   (240),
    .MAX_H   (135)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rect  (req_rect),
    .req_err   (req_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .busy      (busy),
    .done      (done),
    .grant_id  (grant_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pop on transfer, hold check while stalled.
  logic       stall = 1'b0;
  logic [8:0] held  = '0;
  always @(negedge clk) begin
    logic [8:0] e;
    if (!resetn) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_word", 32'(out_word), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(out_word), 32'h1FF);
        end else begin
          e = exp_q.pop_front();
          check("word", 32'(out_word), 32'(e));
        end
      end
      stall = out_valid && !out_ready;
      held  = out_word;
    end
  end

  task automatic set_req(input int i, input logic [8:0] x0, input logic [8:0] x1,
                         input logic [8:0] y0, input logic [8:0] y1, input logic [15:0] c);
    req_rect[52*i +: 52] = {x0, x1, y0, y1, c};
  endtask

  // Header (11 words) plus the first npix_words pixel bytes.
  task automatic push_stream(input logic [8:0] x0, input logic [8:0] x1,
                             input logic [8:0] y0, input logic [8:0] y1,
                             input logic [15:0] c, input int npix_words);
    logic [15:0] a0, a1, b0, b1;
    a0 = {7'd0, x0} + 16'd40;
    a1 = {7'd0, x1} + 16'd40;
    b0 = {7'd0, y0} + 16'd53;
    b1 = {7'd0, y1} + 16'd53;
    exp_q.push_back(9'h02A);
    exp_q.push_back({1'b1, a0[15:8]}); exp_q.push_back({1'b1, a0[7:0]});
    exp_q.push_back({1'b1, a1[15:8]}); exp_q.push_back({1'b1, a1[7:0]});
    exp_q.push_back(9'h02B);
    exp_q.push_back({1'b1, b0[15:8]}); exp_q.push_back({1'b1, b0[7:0]});
    exp_q.push_back({1'b1, b1[15:8]}); exp_q.push_back({1'b1, b1[7:0]});
    exp_q.push_back(9'h02C);
    for (int i = 0; i < npix_words; i++)
      exp_q.push_back((i % 2 == 0) ? {1'b1, c[15:8]} : {1'b1, c[7:0]});
  endtask

  task automatic wait_grant(input int who, input logic err_exp, output int at);
    logic       seen;
    logic [1:0] expv;
    seen = 1'b0;
    at   = 0;
    expv = 2'(1 << who);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    check("grant_seen", 32'(seen), 32'd1);
    if (seen) begin
      at = cyc;
      check("req_ready", 32'(req_ready), 32'(expv));
      check("req_err", 32'(req_err), err_exp ? 32'(expv) : 32'd0);
      check("grant_id", 32'(grant_id), 32'(who));
    end
  endtask

  task automatic wait_done(output int at);
    logic seen;
    seen = 1'b0;
    at   = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      at = cyc;
      check("done_busy", 32'(busy), 32'd0);
      check("done_out_valid", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tg, td, bad;
    logic seen;
    logic [8:0] t1 [13];
    t1 = '{9'h02A, 9'h100, 9'h128, 9'h100, 9'h128, 9'h02B, 9'h100, 9'h135,
           9'h100, 9'h135, 9'h02C, 9'h1F8, 9'h100};

    // Reset state, with a pending request that must not be acknowledged.
    init_done = 1'b1;
    req_valid = 2'b01;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_req_err", 32'(req_err), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    resetn    = 1'b1;
    out_ready = 1'b1;

    // 1x1 red fill, out_ready high: 13 words, done 14 cycles after accept.
    @(posedge clk); #1;
    for (int i = 0; i < 13; i++) exp_q.push_back(t1[i]);
    set_req(0, 9'd0, 9'd0, 9'd0, 9'd0, 16'hF800);
    req_valid = 2'b01;
    wait_grant(0, 1'b0, tg);
    @(posedge clk); #1;
    req_valid = '0;
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_done(td);
    check("latency_1x1", 32'(td - tg), 32'd14);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Rejects on requester 1: x0>x1, then y1=135.
    @(posedge clk); #1;
    set_req(1, 9'd5, 9'd4, 9'd0, 9'd0, 16'h001F);
    req_valid = 2'b10;
    wait_grant(1, 1'b1, tg);
    @(posedge clk); #1;
    req_valid = '0;
    check("rej1_out_valid", 32'(out_valid), 32'd0);
    check("rej1_busy", 32'(busy), 32'd0);
    set_req(1, 9'd0, 9'd0, 9'd0, 9'd135, 16'h001F);
    req_valid = 2'b10;
    wait_grant(1, 1'b1, tg);
    @(posedge clk); #1;
    req_valid = '0;
    check("rej2_out_valid", 32'(out_valid), 32'd0);
    check("rej2_busy", 32'(busy), 32'd0);

    // Both requesters hold 2x1 blue requests: grants alternate 0,1,0,1.
    @(posedge clk); #1;
    set_req(0, 9'd0, 9'd1, 9'd0, 9'd0, 16'h001F);
    set_req(1, 9'd0, 9'd1, 9'd0, 9'd0, 16'h001F);
    for (int g = 0; g < 4; g++) push_stream(9'd0, 9'd1, 9'd0, 9'd0, 16'h001F, 4);
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_grant(g % 2, 1'b0, tg);
      if (g == 3) begin
        @(posedge clk); #1;
        req_valid = '0;
      end
      wait_done(td);
    end
    check("rr_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3x2 fill with random back-pressure: 23 words, stable while stalled.
    @(posedge clk); #1;
    set_req(1, 9'd10, 9'd12, 9'd20, 9'd21, 16'hABCD);
    push_stream(9'd10, 9'd12, 9'd20, 9'd21, 16'hABCD, 12);
    req_valid = 2'b10;
    wait_grant(1, 1'b0, tg);
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      if (k == 0) req_valid = '0;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("stall_done_seen", 32'(seen), 32'd1);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // init_done low blocks grants; raising it grants right away.
    init_done = 1'b0;
    set_req(0, 9'd239, 9'd239, 9'd134, 9'd134, 16'h1234);
    push_stream(9'd239, 9'd239, 9'd134, 9'd134, 16'h1234, 2);
    req_valid = 2'b01;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (req_ready != 2'b00) bad++;
    end
    check("no_grant_init_low", 32'(bad), 32'd0);
    @(posedge clk); #1;
    init_done = 1'b1;
    @(negedge clk);
    check("grant_on_init", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    wait_done(td);
    check("init_queue_empty", 32'(exp_q.size()), 32'd0);

    // Full-screen fill aborted by reset after 7 pixel words.
    @(posedge clk); #1;
    set_req(0, 9'd0, 9'd239, 9'd0, 9'd134, 16'h07E0);
    push_stream(9'd0, 9'd239, 9'd0, 9'd134, 16'h07E0, 7);
    req_valid = 2'b01;
    wait_grant(0, 1'b0, tg);
    @(posedge clk); #1;
    req_valid = '0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin
        seen = 1'b1;
        break;
      end
    end
    check("big_prefix_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_grant_id", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    set_req(0, 9'd0, 9'd0, 9'd0, 9'd0, 16'hF800);
    for (int i = 0; i < 13; i++) exp_q.push_back(t1[i]);
    req_valid = 2'b01;
    wait_grant(0, 1'b0, tg);
    @(posedge clk); #1;
    req_valid = '0;
    wait_done(td);
    check("post_rst_latency", 32'(td - tg), 32'd14);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_fill_scheduler.md
Name: lcd_fill_scheduler

Overview:
- Sequences the ST7789-style SPI LCD after initialisation. Accepts rectangle-fill requests from N_REQ requesters and arbitrates between them round-robin.
- For each granted request it emits the 9-bit word stream for the shared SPI byte transmitter: bit 8 = RS (0 command, 1 data), bits 7:0 = byte.
- Stream per request: CASET + 4 bytes, RASET + 4 bytes, RAMWR, then 2 bytes per pixel.
- Sits between the init sequencer, which asserts init_done, and the bit-serialiser.

Parameters:
- N_REQ, 2, number of requesters (≥2).
- COL_OFS, 40, column offset added to x coordinates (panel window 0x28).
- ROW_OFS, 53, row offset added to y coordinates (panel window 0x35).
- MAX_W, 240, largest legal x coordinate + 1.
- MAX_H, 135, largest legal y coordinate + 1.

Ports:
- clk  in  1  system clock (27 MHz)
- resetn  in  1  asynchronous active-low reset
- init_done  in  1  LCD init complete; no grant while low
- req_valid  in  N_REQ  request pending, one bit per requester
- req_ready  out  N_REQ  one-cycle accept pulse to the granted requester
- req_rect  in  N_REQ*52  per requester i, slice [52*i+:52] = {x0[8:0], x1[8:0], y0[8:0], y1[8:0], color[15:0]}
- req_err  out  N_REQ  one-cycle pulse: request rejected
- out_valid  out  1  out_word valid
- out_ready  in  1  serialiser accepts word
- out_word  out  9  {rs, byte}
- busy  out  1  a request is being streamed
- done  out  1  one-cycle pulse after the last pixel byte is accepted
- grant_id  out  $clog2(N_REQ)  index of the current or last granted requester

Behaviour:
- Reset (asynchronous, any state, including mid-stream):
  - All outputs go to 0, state goes to IDLE, rr pointer goes to 0.
  - The partial stream is abandoned. No words are replayed after reset.
- State machine: IDLE → CASET → RASET → RAMWR → PIXEL → DONE → IDLE.
- IDLE:
  - If init_done=1 and any req_valid is set, pick the first set bit scanning upward from rr pointer, with wrap-around.
  - In that same cycle: pulse req_ready[g], latch that requester's req_rect, and set grant_id=g and rr pointer=g+1 mod N_REQ.
  - Validation happens in the same cycle. Reject if x0>x1, y0>y1, x1≥MAX_W or y1≥MAX_H.
  - On reject: pulse req_err[g] together with req_ready[g], stay in IDLE, and still advance the rr pointer.
  - On accept: set busy=1 and go to CASET.
- Handshake:
  - A word transfers on a cycle with out_valid & out_ready.
  - out_word must hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
  - The next word is presented in the cycle after a transfer; there are no bubbles inside a state.
- CASET (word idx 0..4): 0x02A, then 0x1 data bytes for (x0+COL_OFS)[15:8], (x0+COL_OFS)[7:0], (x1+COL_OFS)[15:8], (x1+COL_OFS)[7:0].
  - Arithmetic is 16-bit, zero-extended.
- RASET (idx 0..4): 0x02B, then the same layout using y and ROW_OFS.
- RAMWR: single word 0x02C.
- PIXEL:
  - Load the pixel counter with (x1-x0+1)*(y1-y0+1); the counter is 17 bits wide.
  - Per pixel emit {1, color[15:8]} then {1, color[7:0]}.
  - Decrement the counter on transfer of the low byte. Leave the state when it reaches 0.
- DONE: one cycle. done=1, busy=0, out_valid=0, then return to IDLE.
  - A new grant is possible no earlier than the cycle after DONE.
- Minimum latency: accept cycle → first word valid on the next cycle.
  - With out_ready tied high, a 1×1 fill takes 13 words, 13 cycles, then DONE.
- Simultaneous requests: exactly one grant per IDLE cycle; the others remain pending.
- A requester deasserting req_valid before grant is simply skipped. req_rect is only sampled in the grant cycle.
- init_done falling mid-stream is ignored; it only gates new grants.
- busy=1 from the cycle after accept through PIXEL. It is 0 in IDLE and DONE.

Decomposition:
- Package lcd_pkg holds:
  - Command constants LCD_CASET=8'h2A, LCD_RASET=8'h2B, LCD_RAMWR=8'h2C.
  - Typedef rect_t, a packed struct {x0, x1, y0, y1, color}.
  - The state enum fsm_e.
- One sub-module: rr_arbiter (N_REQ-wide request vector, rr pointer in, one-hot grant + index out, purely combinational).
- Word-index and pixel counters live in lcd_fill_scheduler.

Test Plan:
- Reset, init_done=1, req0 = (x0=0, x1=0, y0=0, y1=0, color=16'hF800), out_ready=1 → words 02A,100,128,100,128,02B,100,135,100,135,02C,1F8,100; done on cycle 14; req_ready[0] pulse.
- req0 and req1 valid together, both 2×1 blue (001F), twice in succession → grant order 0,1,0,1; each stream has 4 pixel words (11F? no: 100,11F ×2).
- out_ready toggled randomly on a 3×2 fill → out_word stable while stalled; exactly 11+12 words; pixel words alternate hi/lo.
- req1 with x0=5, x1=4 → req_err[1] and req_ready[1] same cycle, no out_valid, rr pointer advances; y1=135 also rejected.
- init_done=0 with req0 valid → no req_ready for 100 cycles; raise init_done → grant the next cycle.
- resetn asserted after 7 pixel words of a 240×135 fill → out_valid=0 and busy=0 immediately; after release, the next request streams from 02A.
